if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a ready/valid instruction memory and fills the IF/ID register.
// A skid register absorbs a response that lands during an ID stall; a kill flag drops stale responses after a redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] fetch_pc_plus4;
    logic [31:0] redirect_pc;
    logic [31:0] redirect_pc_next;
    logic        kill;
    logic        kill_next;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic        redirect;
    logic [31:0] target;
    logic        ifid_flush;
    logic        ifid_load_mem;
    logic        ifid_load_skid;
    logic        skid_load;

    // A redirect only counts when ID is not stalled; low address bits are forced to zero.
    assign redirect       = branch_taken & ~stall;
    assign target         = branch_target & ~32'h0000_0003;
    assign fetch_pc_plus4 = fetch_pc + 32'd4;

    assign imem_req  = (state == WAIT);
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            redirect_pc <= RESET_PC;
            kill        <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            redirect_pc <= redirect_pc_next;
            kill        <= kill_next;
        end
    end

    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        redirect_pc_next = redirect_pc;
        kill_next        = kill;
        ifid_flush       = 1'b0;
        ifid_load_mem    = 1'b0;
        ifid_load_skid   = 1'b0;
        skid_load        = 1'b0;

        case (state)
            BOOT: begin
                state_next = WAIT;
                if (redirect) begin
                    ifid_flush    = 1'b1;
                    fetch_pc_next = target;
                end
            end

            WAIT: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                end
                if (imem_ready) begin
                    kill_next = 1'b0;
                    if (redirect) begin
                        fetch_pc_next = target;
                    end else if (kill) begin
                        fetch_pc_next = redirect_pc;
                    end else if (stall) begin
                        skid_load     = 1'b1;
                        fetch_pc_next = fetch_pc_plus4;
                        state_next    = HOLD;
                    end else begin
                        ifid_load_mem = 1'b1;
                        fetch_pc_next = fetch_pc_plus4;
                    end
                end else if (redirect) begin
                    // Request still in flight: its address must not move, so park the target until it returns.
                    kill_next        = 1'b1;
                    redirect_pc_next = target;
                end
            end

            HOLD: begin
                if (!stall) begin
                    state_next = WAIT;
                    if (redirect) begin
                        ifid_flush    = 1'b1;
                        fetch_pc_next = target;
                    end else begin
                        ifid_load_skid = 1'b1;
                    end
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instruction <= NOP_INSTR;
            if_valid    <= 1'b0;
        end else if (ifid_flush) begin
            instruction <= NOP_INSTR;
            if_valid    <= 1'b0;
        end else if (ifid_load_mem) begin
            pc          <= fetch_pc;
            instruction <= imem_rdata;
            if_valid    <= 1'b1;
        end else if (ifid_load_skid) begin
            pc          <= skid_pc;
            instruction <= skid_instr;
            if_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_pc    <= RESET_PC;
            skid_instr <= NOP_INSTR;
        end else if (skid_load) begin
            skid_pc    <= fetch_pc;
            skid_instr <= imem_rdata;
        end
    end

endmodule
